// File: rtl/multiplexor_pkg.sv
// Shared constants and helpers for the N:1 arbitrated multiplexor.
package multiplexor_pkg;

  localparam int MODE_ROUND_ROBIN    = 0;
  localparam int MODE_FIXED_PRIORITY = 1;

  // A single channel still needs a one-bit index field.
  function automatic int channel_bits(input int channels);
    if (channels < 2) begin
      return 1;
    end else begin
      return $clog2(channels);
    end
  endfunction

endpackage

// File: rtl/priority_select_nx1.sv
// Combinational find-first-from-pointer selector: rotate, pick lowest, rotate back.
module priority_select_nx1 #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IDXW-1:0] gnt_idx_o,
  output logic            any_o
);

  logic [N-1:0]    rot_req_s;
  logic [N-1:0]    rot_gnt_s;
  logic [IDXW-1:0] rot_idx_s;
  logic [IDXW:0]   idx_sum_s;

  // Rotate so the pointer channel sits at bit 0, then isolate the lowest set bit.
  always_comb begin
    rot_req_s = N'({req_i, req_i} >> ptr_i);
    rot_gnt_s = rot_req_s & (~rot_req_s + N'(1));
    gnt_o     = N'(({rot_gnt_s, rot_gnt_s} << ptr_i) >> N);
    any_o     = |req_i;
  end

  // Encode the rotated one-hot, then add the pointer back modulo N.
  always_comb begin
    rot_idx_s = '0;
    for (int i = 0; i < N; i++) begin
      if (rot_gnt_s[i]) begin
        rot_idx_s = rot_idx_s | IDXW'(i);
      end else begin
        rot_idx_s = rot_idx_s;
      end
    end
    idx_sum_s = {1'b0, rot_idx_s} + {1'b0, ptr_i};
    if (idx_sum_s >= (IDXW+1)'(N)) begin
      gnt_idx_o = IDXW'(idx_sum_s - (IDXW+1)'(N));
    end else begin
      gnt_idx_o = idx_sum_s[IDXW-1:0];
    end
  end

endmodule

// File: rtl/multiplexor_arbiter_nx1.sv
// N-input valid/ready multiplexor with internal round-robin or fixed-priority
// arbitration feeding a single registered output stage.
module multiplexor_arbiter_nx1
  import multiplexor_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int CHANNELS     = 4,
  parameter int MODE         = MODE_ROUND_ROBIN,
  parameter int CHANNEL_BITS = channel_bits(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [CHANNEL_BITS-1:0]   out_channel,
  input  logic                      out_ready
);

  logic [CHANNEL_BITS-1:0] ptr_q, ptr_d;
  logic [CHANNEL_BITS-1:0] sel_ptr_s;
  logic [CHANNEL_BITS-1:0] next_ptr_s;
  logic [CHANNELS-1:0]     gnt_s;
  logic [CHANNEL_BITS-1:0] gnt_idx_s;
  logic                    any_s;
  logic                    load_s;
  logic                    xfer_s;
  logic [WIDTH-1:0]        sel_data_s;
  logic                    out_valid_q, out_valid_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic [CHANNEL_BITS-1:0] out_channel_q, out_channel_d;

  // Fixed priority reuses the rotating selector with the start point pinned to 0.
  always_comb begin
    if (MODE == MODE_FIXED_PRIORITY) begin
      sel_ptr_s = '0;
    end else begin
      sel_ptr_s = ptr_q;
    end
  end

  priority_select_nx1 #(
    .N    (CHANNELS),
    .IDXW (CHANNEL_BITS)
  ) u_select (
    .req_i     (in_valid),
    .ptr_i     (sel_ptr_s),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s),
    .any_o     (any_s)
  );

  // Accept strobe: only when the output stage can take a word and outside reset.
  always_comb begin
    load_s = !out_valid_q || out_ready;
    if (reset_n && load_s && any_s) begin
      in_ready = gnt_s;
    end else begin
      in_ready = '0;
    end
    xfer_s = |(in_valid & in_ready);
  end

  // AND-OR data select over the one-hot grant.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_data_s = sel_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt_s[i]}});
    end
  end

  // Output stage and pointer next-state.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    ptr_d         = ptr_q;
    if (gnt_idx_s == CHANNEL_BITS'(CHANNELS-1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = gnt_idx_s + CHANNEL_BITS'(1);
    end
    if (xfer_s) begin
      out_valid_d   = 1'b1;
      out_data_d    = sel_data_s;
      out_channel_d = gnt_idx_s;
      if (MODE == MODE_FIXED_PRIORITY) begin
        ptr_d = '0;
      end else begin
        ptr_d = next_ptr_s;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      ptr_q         <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      ptr_q         <= ptr_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;

endmodule

// File: tb/tb_multiplexor_arbiter_nx1.sv
// Directed bench: round-robin instance (dut0) and fixed-priority instance (dut1).
module tb_multiplexor_arbiter_nx1;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int CB = 2;

  logic          clock;
  logic          reset_n;
  logic [N-1:0]  iv0, ir0, iv1, ir1;
  logic [N*W-1:0] id0, id1;
  logic          ordy0, ordy1, ov0, ov1;
  logic [W-1:0]  od0, od1;
  logic [CB-1:0] oc0, oc1;

  int checks;
  int errors;

  logic [W-1:0] dv0 [N];
  logic [W-1:0] dv1 [N];
  int           rr_exp [6];

  multiplexor_arbiter_nx1 #(.WIDTH(W), .CHANNELS(N), .MODE(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv0), .in_data(id0),
    .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_channel(oc0),
    .out_ready(ordy0)
  );

  multiplexor_arbiter_nx1 #(.WIDTH(W), .CHANNELS(N), .MODE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv1), .in_data(id1),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_channel(oc1),
    .out_ready(ordy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out0(input string tag, input logic v, input logic [31:0] d, input int c);
    chk({tag, "_valid"}, 32'(ov0), 32'(v));
    chk({tag, "_data"}, od0, d);
    chk({tag, "_chan"}, 32'(oc0), 32'(c));
  endtask

  task automatic chk_out1(input string tag, input logic v, input logic [31:0] d, input int c);
    chk({tag, "_valid"}, 32'(ov1), 32'(v));
    chk({tag, "_data"}, od1, d);
    chk({tag, "_chan"}, 32'(oc1), 32'(c));
  endtask

  task automatic after_edge();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    dv0 = '{32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h44444444};
    dv1 = '{32'h0A0A0001, 32'h0B0B0002, 32'h0C0C0003, 32'h0D0D0004};
    rr_exp = '{0, 1, 2, 3, 0, 1};
    id0 = {dv0[3], dv0[2], dv0[1], dv0[0]};
    id1 = {dv1[3], dv1[2], dv1[1], dv1[0]};

    // Reset with every channel requesting.
    reset_n = 1'b0;
    iv0 = 4'b1111; ordy0 = 1'b1;
    iv1 = 4'b1111; ordy1 = 1'b1;
    after_edge();
    chk("rst_ready0", 32'(ir0), 32'(4'b0000));
    chk("rst_ready1", 32'(ir1), 32'(4'b0000));
    chk_out0("rst0", 1'b0, 32'h0, 0);
    chk_out1("rst1", 1'b0, 32'h0, 0);

    // Release with nothing requesting: outputs stay idle.
    @(negedge clock);
    reset_n = 1'b1;
    iv0 = 4'b0000;
    iv1 = 4'b0000;
    after_edge();
    chk_out0("idle0", 1'b0, 32'h0, 0);

    // Round-robin fairness from pointer 0.
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      iv0 = 4'b1111;
      #1;
      chk($sformatf("rr_ready%0d", i), 32'(ir0), 32'(4'b0001 << rr_exp[i]));
      after_edge();
      chk_out0($sformatf("rr%0d", i), 1'b1, dv0[rr_exp[i]], rr_exp[i]);
    end

    // Single transfer on channel 2 (pointer now 2).
    @(negedge clock);
    iv0 = 4'b0100;
    #1;
    chk("single_ready", 32'(ir0), 32'(4'b0100));
    after_edge();
    chk_out0("single", 1'b1, 32'hDEADBEEF, 2);

    // Drain with no new request: valid drops, data and channel hold.
    @(negedge clock);
    iv0 = 4'b0000;
    #1;
    chk("drain_ready", 32'(ir0), 32'(4'b0000));
    after_edge();
    chk_out0("drain", 1'b0, 32'hDEADBEEF, 2);

    // Wrap: pointer 3, only channel 0 requesting.
    @(negedge clock);
    iv0 = 4'b0001;
    #1;
    chk("wrap_ready", 32'(ir0), 32'(4'b0001));
    after_edge();
    chk_out0("wrap", 1'b1, dv0[0], 0);

    // Pointer must now be 1.
    @(negedge clock);
    iv0 = 4'b1111;
    #1;
    chk("ptr1_ready", 32'(ir0), 32'(4'b0010));
    after_edge();
    chk_out0("ptr1", 1'b1, dv0[1], 1);

    // Backpressure for 5 cycles: nothing accepted, output holds, pointer holds at 2.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      iv0 = 4'b0011;
      ordy0 = 1'b0;
      #1;
      chk($sformatf("bp_ready%0d", i), 32'(ir0), 32'(4'b0000));
      after_edge();
      chk_out0($sformatf("bp%0d", i), 1'b1, dv0[1], 1);
    end

    // Release backpressure: from pointer 2 with 4'b0011 channel 0 wins, no bubble.
    @(negedge clock);
    ordy0 = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(ir0), 32'(4'b0001));
    after_edge();
    chk_out0("bp_rel", 1'b1, dv0[0], 0);

    // Asynchronous reset mid-cycle while channel 1 is being offered.
    @(negedge clock);
    iv0 = 4'b0011;
    #1;
    chk("pre_rst_ready", 32'(ir0), 32'(4'b0010));
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(ir0), 32'(4'b0000));
    chk_out0("async_rst", 1'b0, 32'h0, 0);
    after_edge();
    chk_out0("rst_hold", 1'b0, 32'h0, 0);

    // After release the search restarts at channel 0 (pointer 1 would pick 3).
    @(negedge clock);
    reset_n = 1'b1;
    iv0 = 4'b1001;
    #1;
    chk("post_rst_ready", 32'(ir0), 32'(4'b0001));
    after_edge();
    chk_out0("post_rst", 1'b1, dv0[0], 0);

    // Fixed priority: channel 1 wins repeatedly over channel 3.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      iv1 = 4'b1010;
      #1;
      chk($sformatf("fp_ready%0d", i), 32'(ir1), 32'(4'b0010));
      after_edge();
      chk_out1($sformatf("fp%0d", i), 1'b1, dv1[1], 1);
    end

    // Drop channel 1: channel 3 wins next.
    @(negedge clock);
    iv1 = 4'b1000;
    #1;
    chk("fp_drop_ready", 32'(ir1), 32'(4'b1000));
    after_edge();
    chk_out1("fp_drop", 1'b1, dv1[3], 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplexor_arbiter_nx1.md
Name: multiplexor_arbiter_nx1

Overview:
- Parametrised N-input, WIDTH-bit multiplexor with per-channel valid/ready handshakes and built-in arbitration.
- Replaces caller-driven select lines with an internal round-robin or fixed-priority arbiter.
- Winning channel's data and index are registered into a single-entry output stage.
- Sits between multiple producers (register file ports, functional units) and one shared consumer path.

Parameters:
- WIDTH, 32, data width per channel.
- CHANNELS, 4, number of input channels (legal range 2..16).
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (channel 0 highest).
- CHANNEL_BITS, $clog2(CHANNELS), derived width of the channel index; never overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  CHANNELS  per-channel request.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  CHANNELS  one-hot (or zero) accept strobe.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered winning data.
- out_channel  output  CHANNEL_BITS  registered index of the winning channel.
- out_ready  input  1  consumer accepts the output word.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_channel=0.
  - Round-robin pointer=0.
  - in_ready=0 while reset_n=0.
- load = !out_valid | out_ready; the output register may take a new word this cycle.
- Grant g is combinational from in_valid and the pointer:
  - MODE 0: search channels pointer, pointer+1, ..., wrapping modulo CHANNELS; first asserted in_valid wins.
  - MODE 1: lowest-index asserted in_valid wins; pointer unused and held at 0.
- in_ready[g]=1 only when load=1 and some in_valid is set. All other in_ready bits are 0. in_ready never asserts for a channel whose in_valid=0.
- A transfer on channel g occurs when in_valid[g] & in_ready[g]. At the next rising edge:
  - out_valid=1, out_data=in_data[g], out_channel=g.
  - MODE 0: pointer = (g+1) mod CHANNELS, so wrap-around from CHANNELS-1 goes to 0.
- Latency: one cycle from accepted input to out_valid.
- Throughput: one word per cycle while out_ready stays high.
- Consumer side:
  - out_valid & out_ready with no new transfer: out_valid goes to 0; out_data and out_channel hold their last values.
  - out_valid & out_ready with a new transfer in the same cycle: the register is replaced seamlessly with no bubble.
  - out_valid & !out_ready: register holds, in_ready all 0, pointer holds.
- No in_valid asserted: no grant and the pointer holds.
- Producers must hold in_valid and in_data stable until accepted. The block does not check this.
- in_ready depends combinationally on in_valid and out_ready. No combinational path exists from in_data to any output.
- Reset mid-transfer: any in-flight word is discarded, the pointer returns to 0, and no in_ready is issued during reset.

Decomposition:
- Shared package multiplexor_pkg:
  - MODE_ROUND_ROBIN=0 and MODE_FIXED_PRIORITY=1 constants.
  - Function computing the channel-index width.
- One sub-module: priority_select_nx1.
  - Purely combinational.
  - Inputs: request vector and start pointer.
  - Outputs: one-hot grant, binary grant index, any-request flag.
  - Implemented by rotate, find-first, rotate-back; reused for both modes (pointer tied to 0 in MODE 1).
- The data select is an AND-OR reduction over the one-hot grant. It is not a tree of 2:1 muxes.

Test Plan:
- Reset/idle: hold reset_n=0 with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_channel=0; after release with in_valid=0 -> outputs unchanged.
- Single transfer: CHANNELS=4, in_valid=4'b0100, in_data[2]=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100 in that cycle; next cycle out_valid=1, out_data=32'hDEADBEEF, out_channel=2.
- Round-robin fairness: MODE 0, in_valid=4'b1111 held, out_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, one word per cycle, no bubbles.
- Fixed priority: MODE 1, in_valid=4'b1010 held -> channel 1 granted every cycle; drop in_valid[1] -> channel 3 granted the next cycle.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles with in_valid=4'b0011 -> in_ready=0, out_data stable, pointer stable; raise out_ready -> the pending word drains and the next grant loads in the same cycle.
- Wrap and reset: pointer at 3 after granting channel 2, in_valid=4'b0001 -> channel 0 granted and pointer=1; assert reset_n=0 asynchronously mid-cycle -> out_valid drops immediately and the next grant after release starts from channel 0.
